// File: rtl/washer_controller_if.sv
// Signal bundle between the wash sequencer and its surroundings (panel inputs,
// washerTimer handshake, valve and motor enables).
interface washer_controller_if;
    logic       start;
    logic       lid_open;
    logic       cancel;
    logic       Tf;
    logic       Tw;
    logic       Td;
    logic       Tr;
    logic       Ts;
    logic [1:0] load;
    logic       tmr_R;
    logic       hold;
    logic       fill_v;
    logic       drain_v;
    logic       agitate;
    logic       spin;
    logic       busy;
    logic       done;

    modport master (
        output start, lid_open, cancel, Tf, Tw, Td, Tr, Ts,
        input  load, tmr_R, hold, fill_v, drain_v, agitate, spin, busy, done
    );

    modport slave (
        input  start, lid_open, cancel, Tf, Tw, Td, Tr, Ts,
        output load, tmr_R, hold, fill_v, drain_v, agitate, spin, busy, done
    );
endinterface

// File: rtl/washer_controller.sv
// Wash-cycle sequencer: fill, wash, drain, fill, rinse, drain, spin, driven by
// washerTimer expiry flags, with cancel-to-drain and lid-open pause.
module washer_controller (
    input  logic                 clk,
    input  logic                 R_n,
    washer_controller_if.slave   bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FILL1  = 4'd1;
    localparam logic [3:0] S_WASH   = 4'd2;
    localparam logic [3:0] S_DRAIN1 = 4'd3;
    localparam logic [3:0] S_FILL2  = 4'd4;
    localparam logic [3:0] S_RINSE  = 4'd5;
    localparam logic [3:0] S_DRAIN2 = 4'd6;
    localparam logic [3:0] S_SPIN   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [1:0] LD_FILL_DRAIN = 2'b00;
    localparam logic [1:0] LD_AGITATE    = 2'b01;
    localparam logic [1:0] LD_SPIN       = 2'b10;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [1:0] load_r;
    logic       tmr_r;
    logic       hold_r;
    logic       cxl_r;
    logic       qual;
    logic       take_cancel;

    function automatic logic [1:0] load_code(input logic [3:0] s);
        case (s)
            S_WASH, S_RINSE: load_code = LD_AGITATE;
            S_SPIN:          load_code = LD_SPIN;
            default:         load_code = LD_FILL_DRAIN;
        endcase
    endfunction

    function automatic logic is_motor(input logic [3:0] s);
        is_motor = (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
    endfunction

    function automatic logic is_parked(input logic [3:0] s);
        is_parked = (s == S_IDLE) || (s == S_DONE);
    endfunction

    // A flag counts only once the timer has left its restart cycle and is not paused,
    // so a flag still high from the previous period cannot skip a state.
    assign qual = ~tmr_r & ~hold_r;

    always_comb begin
        state_nxt   = state;
        take_cancel = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.lid_open) state_nxt = S_FILL1;
            end
            S_FILL1: begin
                if (bus.cancel) begin
                    state_nxt   = S_DRAIN2;
                    take_cancel = 1'b1;
                end else if (qual && bus.Tf) begin
                    state_nxt = S_WASH;
                end
            end
            S_WASH: begin
                if (bus.cancel) begin
                    state_nxt   = S_DRAIN2;
                    take_cancel = 1'b1;
                end else if (qual && bus.Tw) begin
                    state_nxt = S_DRAIN1;
                end
            end
            S_DRAIN1: begin
                if (bus.cancel) begin
                    state_nxt   = S_DRAIN2;
                    take_cancel = 1'b1;
                end else if (qual && bus.Td) begin
                    state_nxt = S_FILL2;
                end
            end
            S_FILL2: begin
                if (bus.cancel) begin
                    state_nxt   = S_DRAIN2;
                    take_cancel = 1'b1;
                end else if (qual && bus.Tf) begin
                    state_nxt = S_RINSE;
                end
            end
            S_RINSE: begin
                if (bus.cancel) begin
                    state_nxt   = S_DRAIN2;
                    take_cancel = 1'b1;
                end else if (qual && bus.Tr) begin
                    state_nxt = S_DRAIN2;
                end
            end
            S_DRAIN2: begin
                if (qual && bus.Td) state_nxt = cxl_r ? S_DONE : S_SPIN;
            end
            S_SPIN: begin
                if (qual && bus.Ts) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.lid_open) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every state change restarts the timer for exactly one cycle; the parked
    // states keep it in restart indefinitely.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state  <= S_IDLE;
            load_r <= LD_FILL_DRAIN;
            tmr_r  <= 1'b1;
            hold_r <= 1'b0;
            cxl_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            load_r <= load_code(state_nxt);
            tmr_r  <= (state_nxt != state) || is_parked(state_nxt);
            hold_r <= bus.lid_open && is_motor(state_nxt);
            if (state_nxt == S_IDLE)
                cxl_r <= 1'b0;
            else if (take_cancel)
                cxl_r <= 1'b1;
        end
    end

    // Motors are gated directly by the lid switch so they stop in the same cycle.
    assign bus.load    = load_r;
    assign bus.tmr_R   = tmr_r;
    assign bus.hold    = hold_r;
    assign bus.fill_v  = (state == S_FILL1) || (state == S_FILL2);
    assign bus.drain_v = (state == S_DRAIN1) || (state == S_DRAIN2) || (state == S_SPIN);
    assign bus.agitate = ((state == S_WASH) || (state == S_RINSE)) && !bus.lid_open;
    assign bus.spin    = (state == S_SPIN) && !bus.lid_open;
    assign bus.busy    = !is_parked(state);
    assign bus.done    = (state == S_DONE);

endmodule

// File: tb/tb_washer_controller.sv
// Directed bench for washer_controller: expected output vectors are queued as
// each step is driven and compared when the DUT responds.
module tb_washer_controller;

    localparam int S_IDLE   = 0;
    localparam int S_FILL1  = 1;
    localparam int S_WASH   = 2;
    localparam int S_DRAIN1 = 3;
    localparam int S_FILL2  = 4;
    localparam int S_RINSE  = 5;
    localparam int S_DRAIN2 = 6;
    localparam int S_SPIN   = 7;
    localparam int S_DONE   = 8;

    localparam int F_TF = 0;
    localparam int F_TW = 1;
    localparam int F_TD = 2;
    localparam int F_TR = 3;
    localparam int F_TS = 4;

    logic clk;
    logic R_n;

    washer_controller_if bus ();

    washer_controller dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Expected {load, tmr_R, hold, fill_v, drain_v, agitate, spin, busy, done}
    function automatic logic [9:0] expv(input int s, input bit r, input bit h, input bit lid);
        logic [1:0] ld;
        bit parked;
        parked = (s == S_IDLE) || (s == S_DONE);
        if (s == S_WASH || s == S_RINSE) ld = 2'b01;
        else if (s == S_SPIN)            ld = 2'b10;
        else                             ld = 2'b00;
        expv = {ld,
                (parked ? 1'b1 : r),
                h,
                (s == S_FILL1 || s == S_FILL2),
                (s == S_DRAIN1 || s == S_DRAIN2 || s == S_SPIN),
                ((s == S_WASH || s == S_RINSE) && !lid),
                (s == S_SPIN && !lid),
                !parked,
                (s == S_DONE)};
    endfunction

    function automatic logic [9:0] obs();
        obs = {bus.load, bus.tmr_R, bus.hold, bus.fill_v, bus.drain_v,
               bus.agitate, bus.spin, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [9:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare();
        logic [9:0] e;
        string      t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs());
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs() === e)
            else begin
                miscompares++;
                $error("FAIL %s observed=%b expected=%b", t, obs(), e);
            end
        end
    endtask

    task automatic set_flag(input int f, input logic v);
        case (f)
            F_TF: bus.Tf = v;
            F_TW: bus.Tw = v;
            F_TD: bus.Td = v;
            F_TR: bus.Tr = v;
            default: bus.Ts = v;
        endcase
    endtask

    // Timer model: restart falls, flag rises 15 cycles later for one cycle.
    task automatic expire(input string tag, input int cur, input int f, input int nxt);
        push({tag, "_rfall"}, expv(cur, 0, 0, 0));
        tick();
        compare();
        repeat (14) tick();
        set_flag(f, 1'b1);
        push({tag, "_adv"}, expv(nxt, 1, 0, 0));
        tick();
        set_flag(f, 1'b0);
        compare();
    endtask

    initial begin
        R_n          = 1'b0;
        bus.start    = 1'b0;
        bus.lid_open = 1'b0;
        bus.cancel   = 1'b0;
        bus.Tf       = 1'b0;
        bus.Tw       = 1'b0;
        bus.Td       = 1'b0;
        bus.Tr       = 1'b0;
        bus.Ts       = 1'b0;

        // Reset held 100 ns
        push("reset_hold", expv(S_IDLE, 1, 0, 0));
        #50;
        compare();
        #50;
        R_n = 1'b1;
        push("reset_release", expv(S_IDLE, 1, 0, 0));
        tick();
        compare();

        // Start with lid open must not begin a cycle
        bus.start    = 1'b1;
        bus.lid_open = 1'b1;
        push("start_lid_open", expv(S_IDLE, 1, 0, 1));
        tick();
        compare();
        bus.start    = 1'b0;
        bus.lid_open = 1'b0;

        // Full cycle, FILL1 entered with a stale Tf already high
        bus.Tf    = 1'b1;
        bus.start = 1'b1;
        push("fill1_entry", expv(S_FILL1, 1, 0, 0));
        tick();
        bus.start = 1'b0;
        compare();
        push("stale_tf_ignored", expv(S_FILL1, 0, 0, 0));
        tick();
        compare();
        push("tf_qualified", expv(S_WASH, 1, 0, 0));
        tick();
        bus.Tf = 1'b0;
        compare();
        expire("wash",   S_WASH,   F_TW, S_DRAIN1);
        expire("drain1", S_DRAIN1, F_TD, S_FILL2);
        expire("fill2",  S_FILL2,  F_TF, S_RINSE);
        expire("rinse",  S_RINSE,  F_TR, S_DRAIN2);
        expire("drain2", S_DRAIN2, F_TD, S_SPIN);

        // Lid pause during SPIN
        push("spin_rfall", expv(S_SPIN, 0, 0, 0));
        tick();
        compare();
        repeat (3) tick();
        bus.lid_open = 1'b1;
        push("spin_lid_motor_off", expv(S_SPIN, 0, 0, 1));
        #1;
        compare();
        push("spin_hold_rise", expv(S_SPIN, 0, 1, 1));
        tick();
        compare();
        bus.Ts = 1'b1;
        push("spin_ts_while_held", expv(S_SPIN, 0, 1, 1));
        tick();
        bus.Ts = 1'b0;
        compare();
        repeat (17) tick();
        bus.lid_open = 1'b0;
        push("spin_lid_closed_motor_on", expv(S_SPIN, 0, 1, 0));
        #1;
        compare();
        push("spin_hold_fall", expv(S_SPIN, 0, 0, 0));
        tick();
        compare();
        bus.Ts = 1'b1;
        push("spin_to_done", expv(S_DONE, 1, 0, 0));
        tick();
        bus.Ts = 1'b0;
        compare();

        // DONE exits on lid open
        bus.lid_open = 1'b1;
        push("done_exit", expv(S_IDLE, 1, 0, 1));
        tick();
        compare();
        bus.lid_open = 1'b0;

        // Cancel coinciding with Tw in WASH
        bus.start = 1'b1;
        push("c_fill1_entry", expv(S_FILL1, 1, 0, 0));
        tick();
        bus.start = 1'b0;
        compare();
        expire("c_fill1", S_FILL1, F_TF, S_WASH);
        push("c_wash_rfall", expv(S_WASH, 0, 0, 0));
        tick();
        compare();
        repeat (4) tick();
        bus.Tw     = 1'b1;
        bus.cancel = 1'b1;
        push("cancel_beats_tw", expv(S_DRAIN2, 1, 0, 0));
        tick();
        bus.Tw     = 1'b0;
        bus.cancel = 1'b0;
        compare();
        expire("c_drain2_skip_spin", S_DRAIN2, F_TD, S_DONE);
        bus.lid_open = 1'b1;
        push("c_done_exit", expv(S_IDLE, 1, 0, 1));
        tick();
        compare();
        bus.lid_open = 1'b0;

        // Asynchronous reset in the middle of WASH
        bus.start = 1'b1;
        push("r_fill1_entry", expv(S_FILL1, 1, 0, 0));
        tick();
        bus.start = 1'b0;
        compare();
        expire("r_fill1", S_FILL1, F_TF, S_WASH);
        push("r_wash_agitate", expv(S_WASH, 0, 0, 0));
        tick();
        compare();
        R_n = 1'b0;
        push("async_reset_mid_wash", expv(S_IDLE, 1, 0, 0));
        #1;
        compare();
        repeat (2) tick();
        R_n = 1'b1;
        push("post_reset_idle", expv(S_IDLE, 1, 0, 0));
        tick();
        compare();

        // Full cycle after reset: cancel bit must not survive reset
        bus.start = 1'b1;
        push("p_fill1_entry", expv(S_FILL1, 1, 0, 0));
        tick();
        bus.start = 1'b0;
        compare();
        expire("p_fill1",  S_FILL1,  F_TF, S_WASH);
        expire("p_wash",   S_WASH,   F_TW, S_DRAIN1);
        expire("p_drain1", S_DRAIN1, F_TD, S_FILL2);
        expire("p_fill2",  S_FILL2,  F_TF, S_RINSE);
        expire("p_rinse",  S_RINSE,  F_TR, S_DRAIN2);
        expire("p_drain2", S_DRAIN2, F_TD, S_SPIN);
        expire("p_spin",   S_SPIN,   F_TS, S_DONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
